// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the parametrised pipeline controller.
package pipe_ctrl_pkg;

    // Jump/flush sequencing states.
    typedef enum logic [1:0] {
        PC_IDLE  = 2'd0,
        PC_PEND  = 2'd1,
        PC_FLUSH = 2'd2
    } pc_state_e;

    // Stage indices for the classic four-stage core; index 0 is the most upstream stage.
    localparam int STG_PC = 0;
    localparam int STG_IF = 1;
    localparam int STG_ID = 2;
    localparam int STG_EX = 3;

    // Width of a counter that must be able to hold the value max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_gen_if.sv
// Bundle between the core stages / CLINT / JTAG and the pipeline controller.
interface pipe_ctrl_gen_if #(
    parameter int NUM_STAGES = 4,
    parameter int ADDR_W     = 32,
    parameter int PERF_W     = 32
);
    logic [NUM_STAGES-1:0] stall_req_i;
    logic                  jump_assert_i;
    logic [ADDR_W-1:0]     jump_addr_i;
    logic                  perf_clr_i;
    logic [NUM_STAGES-1:0] stall_o;
    logic                  flush_o;
    logic [ADDR_W-1:0]     flush_addr_o;
    logic                  jump_pending_o;
    logic                  stall_timeout_o;
    logic [PERF_W-1:0]     stall_cycles_o;

    // Core side: raises requests, consumes stall/flush controls.
    modport master (
        output stall_req_i, jump_assert_i, jump_addr_i, perf_clr_i,
        input  stall_o, flush_o, flush_addr_o, jump_pending_o,
               stall_timeout_o, stall_cycles_o
    );

    // Controller side.
    modport slave (
        input  stall_req_i, jump_assert_i, jump_addr_i, perf_clr_i,
        output stall_o, flush_o, flush_addr_o, jump_pending_o,
               stall_timeout_o, stall_cycles_o
    );
endinterface

// File: rtl/stall_monitor.sv
// Stall watchdog and saturating stall-cycle performance counter.
module stall_monitor
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 256,
    parameter int PERF_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              any_stall_i,
    input  logic              perf_clr_i,
    output logic              stall_timeout_o,
    output logic [PERF_W-1:0] stall_cycles_o
);
    localparam int WD_W = cnt_width(STALL_TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT);

    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic [PERF_W-1:0] perf_q, perf_d;

    // Next-state: watchdog counts consecutive stall cycles, perf counts all of them.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        perf_d   = perf_q;
        if (!any_stall_i) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WD_MAX) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
        // Clear wins over a same-cycle increment.
        if (perf_clr_i) begin
            perf_d = '0;
        end else if (any_stall_i && (perf_q != '1)) begin
            perf_d = perf_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            perf_q   <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            perf_q   <= perf_d;
        end
    end

    assign stall_timeout_o = (wd_cnt_q == WD_MAX);
    assign stall_cycles_o  = perf_q;

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Parametrised pipeline controller: stall cascade, pending-jump handling,
// stretched flush, stall watchdog and stall performance counter.
module pipe_ctrl_gen
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES    = 4,
    parameter int ADDR_W        = 32,
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 256,
    parameter int PERF_W        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_ctrl_gen_if.slave  bus
);
    localparam int CNT_W = cnt_width(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

    logic [NUM_STAGES-1:0] stall_c;
    logic                  fetch_frozen;

    pc_state_e             state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  flush_c;
    logic [ADDR_W-1:0]     flush_addr_c;
    logic                  issue_c;

    // A stall request from any stage freezes that stage and everything upstream of it.
    for (genvar j = 0; j < NUM_STAGES; j++) begin : g_cascade
        assign stall_c[j] = |bus.stall_req_i[NUM_STAGES-1:j];
    end

    assign fetch_frozen = stall_c[STG_PC];

    // Jump sequencing: decide flush outputs and next state for the current cycle.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        flush_c      = 1'b0;
        flush_addr_c = addr_q;
        issue_c      = 1'b0;

        unique case (state_q)
            PC_IDLE: begin
                flush_addr_c = bus.jump_addr_i;
                if (bus.jump_assert_i) begin
                    addr_d = bus.jump_addr_i;
                    if (fetch_frozen) begin
                        state_d = PC_PEND;
                    end else begin
                        flush_c = 1'b1;
                        issue_c = 1'b1;
                    end
                end
            end
            PC_PEND: begin
                // Newest jump wins, including in the cycle the stall drops.
                if (bus.jump_assert_i) begin
                    addr_d       = bus.jump_addr_i;
                    flush_addr_c = bus.jump_addr_i;
                end
                if (!fetch_frozen) begin
                    flush_c = 1'b1;
                    issue_c = 1'b1;
                end
            end
            PC_FLUSH: begin
                // Stalls are deliberately ignored here; stages prioritise flush locally.
                flush_c = 1'b1;
                if (bus.jump_assert_i) begin
                    addr_d       = bus.jump_addr_i;
                    flush_addr_c = bus.jump_addr_i;
                    cnt_d        = CNT_RELOAD;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = PC_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = PC_IDLE;
        endcase

        // A flush issued from IDLE or PEND is stretched only when more than one cycle is configured.
        if (issue_c) begin
            if (FLUSH_CYCLES > 1) begin
                state_d = PC_FLUSH;
                cnt_d   = CNT_RELOAD;
            end else begin
                state_d = PC_IDLE;
            end
        end
    end

    // FSM state, latched redirect address and flush stretch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PC_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low while reset is held, whatever the inputs are doing.
    assign bus.stall_o        = rst_n ? stall_c : '0;
    assign bus.flush_o        = rst_n & flush_c;
    assign bus.flush_addr_o   = rst_n ? flush_addr_c : '0;
    assign bus.jump_pending_o = (state_q == PC_PEND);

    stall_monitor #(
        .STALL_TIMEOUT (STALL_TIMEOUT),
        .PERF_W        (PERF_W)
    ) u_stall_monitor (
        .clk             (clk),
        .rst_n           (rst_n),
        .any_stall_i     (|bus.stall_o),
        .perf_clr_i      (bus.perf_clr_i),
        .stall_timeout_o (bus.stall_timeout_o),
        .stall_cycles_o  (bus.stall_cycles_o)
    );

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench for pipe_ctrl_gen: cascade, immediate/pending jumps,
// flush stretching, watchdog, perf saturation/clear and mid-operation reset.
module tb_pipe_ctrl_gen;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int FC = 3;
    localparam int ST = 8;
    localparam int PW = 4;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    pipe_ctrl_gen_if #(.NUM_STAGES(NS), .ADDR_W(AW), .PERF_W(PW)) bus ();

    pipe_ctrl_gen #(
        .NUM_STAGES    (NS),
        .ADDR_W        (AW),
        .FLUSH_CYCLES  (FC),
        .STALL_TIMEOUT (ST),
        .PERF_W        (PW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        // Reset with active inputs: every output must still be 0.
        rst_n              = 1'b0;
        bus.stall_req_i    = 4'b1000;
        bus.jump_assert_i  = 1'b1;
        bus.jump_addr_i    = 32'hDEAD_BEEF;
        bus.perf_clr_i     = 1'b0;
        #3;
        check("rst_stall", bus.stall_o, 4'b0000);
        check("rst_flush", bus.flush_o, 1'b0);
        check("rst_faddr", bus.flush_addr_o, 32'h0);
        check("rst_pend", bus.jump_pending_o, 1'b0);
        check("rst_tmo", bus.stall_timeout_o, 1'b0);
        check("rst_perf", bus.stall_cycles_o, 4'd0);
        tick();
        tick();
        bus.stall_req_i   = '0;
        bus.jump_assert_i = 1'b0;
        bus.jump_addr_i   = '0;
        rst_n             = 1'b1;
        tick();
        check("post_rst_flush", bus.flush_o, 1'b0);

        // T1 stall cascade.
        bus.stall_req_i = 4'b0100; #1;
        check("casc_0100", bus.stall_o, 4'b0111);
        check("casc_noflush", bus.flush_o, 1'b0);
        bus.stall_req_i = 4'b1000; #1;
        check("casc_1000", bus.stall_o, 4'b1111);
        bus.stall_req_i = 4'b0001; #1;
        check("casc_0001", bus.stall_o, 4'b0001);
        bus.stall_req_i = 4'b0000; #1;
        check("casc_0000", bus.stall_o, 4'b0000);

        // T2 immediate jump, flush stretched to 3 cycles.
        tick();
        bus.jump_assert_i = 1'b1;
        bus.jump_addr_i   = 32'h8000_0100;
        #1;
        check("imm_flush_c0", bus.flush_o, 1'b1);
        check("imm_addr_c0", bus.flush_addr_o, 32'h8000_0100);
        tick();
        bus.jump_assert_i = 1'b0;
        bus.jump_addr_i   = 32'h0;
        #1;
        check("imm_flush_c1", bus.flush_o, 1'b1);
        check("imm_addr_c1", bus.flush_addr_o, 32'h8000_0100);
        tick();
        check("imm_flush_c2", bus.flush_o, 1'b1);
        check("imm_addr_c2", bus.flush_addr_o, 32'h8000_0100);
        tick();
        check("imm_flush_c3", bus.flush_o, 1'b0);

        // T3 pending jump held behind an IF stall, overwritten by a later jump.
        bus.stall_req_i   = 4'b0010;
        bus.jump_assert_i = 1'b1;
        bus.jump_addr_i   = 32'h200;
        #1;
        check("pend_stall", bus.stall_o, 4'b0011);
        check("pend_noflush0", bus.flush_o, 1'b0);
        tick();
        bus.jump_assert_i = 1'b0;
        #1;
        check("pend_flag1", bus.jump_pending_o, 1'b1);
        check("pend_noflush1", bus.flush_o, 1'b0);
        tick();
        bus.jump_assert_i = 1'b1;
        bus.jump_addr_i   = 32'h300;
        #1;
        check("pend_noflush2", bus.flush_o, 1'b0);
        tick();
        bus.jump_assert_i = 1'b0;
        bus.jump_addr_i   = 32'h0;
        #1;
        check("pend_flag3", bus.jump_pending_o, 1'b1);
        bus.stall_req_i = 4'b0000;
        #1;
        check("pend_rel_flush", bus.flush_o, 1'b1);
        check("pend_rel_addr", bus.flush_addr_o, 32'h300);
        tick();
        check("pend_fl1", bus.flush_o, 1'b1);
        check("pend_fl1_addr", bus.flush_addr_o, 32'h300);
        check("pend_cleared", bus.jump_pending_o, 1'b0);
        tick();
        check("pend_fl2", bus.flush_o, 1'b1);
        tick();
        check("pend_done", bus.flush_o, 1'b0);

        // New jump in the same cycle the stall drops: flush uses the incoming address.
        bus.stall_req_i   = 4'b0010;
        bus.jump_assert_i = 1'b1;
        bus.jump_addr_i   = 32'h400;
        tick();
        bus.stall_req_i   = 4'b0000;
        bus.jump_addr_i   = 32'h500;
        #1;
        check("pend_same_flush", bus.flush_o, 1'b1);
        check("pend_same_addr", bus.flush_addr_o, 32'h500);
        tick();
        bus.jump_assert_i = 1'b0;
        bus.jump_addr_i   = 32'h0;
        #1;
        check("pend_same_latched", bus.flush_addr_o, 32'h500);
        tick();
        tick();
        check("pend_same_done", bus.flush_o, 1'b0);

        // T4 watchdog: 10 cycles of EX stall with timeout 8.
        bus.perf_clr_i = 1'b1;
        tick();
        bus.perf_clr_i = 1'b0;
        #1;
        check("wd_perf_clr", bus.stall_cycles_o, 4'd0);
        bus.stall_req_i = 4'b1000;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("wd_tmo_%0d", i), bus.stall_timeout_o, (i >= ST) ? 1'b1 : 1'b0);
        end
        bus.stall_req_i = 4'b0000;
        #1;
        check("wd_perf10", bus.stall_cycles_o, 4'd10);
        check("wd_hold_rel", bus.stall_timeout_o, 1'b1);
        tick();
        check("wd_fall", bus.stall_timeout_o, 1'b0);
        check("wd_perf_hold", bus.stall_cycles_o, 4'd10);

        // T5 perf counter saturation and clear priority.
        bus.stall_req_i = 4'b0001;
        for (int i = 0; i < 20; i++) tick();
        check("perf_sat", bus.stall_cycles_o, 4'd15);
        bus.perf_clr_i = 1'b1;
        tick();
        check("perf_clr_stall", bus.stall_cycles_o, 4'd0);
        bus.perf_clr_i = 1'b0;
        tick();
        check("perf_resume", bus.stall_cycles_o, 4'd1);
        bus.stall_req_i = 4'b0000;
        tick();

        // T6a reset while a jump is pending.
        bus.stall_req_i   = 4'b0100;
        bus.jump_assert_i = 1'b1;
        bus.jump_addr_i   = 32'h600;
        tick();
        bus.jump_assert_i = 1'b0;
        #1;
        check("rstp_pend", bus.jump_pending_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstp_pend0", bus.jump_pending_o, 1'b0);
        check("rstp_stall0", bus.stall_o, 4'b0000);
        check("rstp_flush0", bus.flush_o, 1'b0);
        check("rstp_perf0", bus.stall_cycles_o, 4'd0);
        bus.stall_req_i = 4'b0000;
        tick();
        rst_n = 1'b1;
        #1;
        check("rstp_rel_flush", bus.flush_o, 1'b0);
        tick();
        check("rstp_rel_flush2", bus.flush_o, 1'b0);
        check("rstp_rel_pend", bus.jump_pending_o, 1'b0);

        // T6b reset during a stretched flush.
        bus.jump_assert_i = 1'b1;
        bus.jump_addr_i   = 32'h700;
        #1;
        check("rstf_flush_c0", bus.flush_o, 1'b1);
        tick();
        bus.jump_assert_i = 1'b0;
        #1;
        check("rstf_flush_c1", bus.flush_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstf_flush0", bus.flush_o, 1'b0);
        check("rstf_addr0", bus.flush_addr_o, 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rstf_rel_flush", bus.flush_o, 1'b0);
        tick();
        check("rstf_rel_flush2", bus.flush_o, 1'b0);
        bus.jump_assert_i = 1'b1;
        bus.jump_addr_i   = 32'h800;
        #1;
        check("rstf_new_flush", bus.flush_o, 1'b1);
        check("rstf_new_addr", bus.flush_addr_o, 32'h800);
        tick();
        bus.jump_assert_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
